// File: rtl/dds_pkg.sv
// Shared definitions for the DDS capture path: default sample width,
// capture FSM state encoding and trigger mode codes.
package dds_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam logic TRIG_IMMEDIATE = 1'b0;
    localparam logic TRIG_ZEROX     = 1'b1;

endpackage

// File: rtl/dds_capture_ram.sv
// Simple dual-port capture memory: one write port, one registered read port.
// Written so synthesis maps it onto a block RAM; contents are never reset.
module dds_capture_ram #(
    parameter int AddrWidth = 10,
    parameter int DataWidth = 16
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [DataWidth-1:0] rd_data
);

    logic [DataWidth-1:0] mem [2**AddrWidth];

    // Write port: one sample per enabled cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: output register only loads on a read, so it holds otherwise
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dds_sample_capture.sv
// Capture end of the DDS sample stream. After Arm the block stores samples
// (immediately or from the first rising zero-crossing), optionally keeping
// only one of every Decim+1 qualified samples, into a capture RAM that the
// host reads back through an addressed port once the capture has finished.
module dds_sample_capture
    import dds_pkg::*;
#(
    parameter int AddrWidth  = 10,
    parameter int DataWidth  = DATA_WIDTH_DEF,
    parameter int DecimWidth = 8
) (
    input  logic                  DAC_clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DataWidth-1:0]  SampleIn,
    input  logic                  SampleValid,
    input  logic                  Arm,
    input  logic                  Abort,
    input  logic                  TrigMode,
    input  logic [DecimWidth-1:0] Decim,
    input  logic [AddrWidth:0]    CaptureLen,
    output logic                  Busy,
    output logic                  Done,
    output logic [AddrWidth:0]    WrCount,
    input  logic                  RdEn,
    input  logic [AddrWidth-1:0]  RdAddress,
    output logic [DataWidth-1:0]  RdData,
    output logic                  RdValid,
    output logic                  RdErr
);

    localparam logic [AddrWidth:0] FULL_LEN = {1'b1, {AddrWidth{1'b0}}};
    localparam logic [AddrWidth:0] ONE_LEN  = (AddrWidth+1)'(1);

    // Zero or oversize lengths mean "fill the whole buffer"
    function automatic logic [AddrWidth:0] clamp_len(input logic [AddrWidth:0] req);
        if (req == '0 || req > FULL_LEN) begin
            return FULL_LEN;
        end
        return req;
    endfunction

    cap_state_t             state;
    logic                   busy_r;
    logic                   done_r;
    logic                   trig_mode_l;
    logic [DecimWidth-1:0]  decim_l;
    logic [AddrWidth:0]     len_l;
    logic [DecimWidth-1:0]  decim_cnt;
    logic [AddrWidth:0]     wr_count;
    logic [AddrWidth:0]     wr_count_inc;
    logic                   prev_neg;

    logic signed [DataWidth-1:0] sample_s;
    logic                   sample_neg;
    logic                   qual;
    logic                   capturing;
    logic                   armed_hit;
    logic                   cap_hit;
    logic                   wr_en;
    logic [AddrWidth-1:0]   wr_addr;

    logic                   rd_vld_p1;
    logic                   rd_err_p1;
    logic                   rd_zero_p1;
    logic [DataWidth-1:0]   ram_q;

    assign sample_s     = SampleIn;
    assign sample_neg   = (sample_s < 0);
    assign qual         = en & SampleValid;
    assign capturing    = (state == ST_ARMED) || (state == ST_CAPTURE);
    assign wr_count_inc = wr_count + ONE_LEN;

    // A trigger sample is stored at address 0 in the same cycle it is detected
    assign armed_hit = qual && (state == ST_ARMED) && (trig_mode_l == TRIG_ZEROX)
                       && prev_neg && !sample_neg;
    assign cap_hit   = qual && (state == ST_CAPTURE) && (decim_cnt == '0);
    assign wr_en     = (armed_hit || cap_hit) && !Abort;
    assign wr_addr   = armed_hit ? '0 : wr_count[AddrWidth-1:0];

    // Capture FSM with trigger detection, decimation and sample counting
    always_ff @(posedge DAC_clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            trig_mode_l <= TRIG_IMMEDIATE;
            decim_l     <= '0;
            len_l       <= FULL_LEN;
            decim_cnt   <= '0;
            wr_count    <= '0;
            prev_neg    <= 1'b0;
        end else if (Abort) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Arm) begin
                        trig_mode_l <= TrigMode;
                        decim_l     <= Decim;
                        len_l       <= clamp_len(CaptureLen);
                        wr_count    <= '0;
                        decim_cnt   <= '0;
                        prev_neg    <= 1'b0;
                        done_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        state       <= (TrigMode == TRIG_ZEROX) ? ST_ARMED : ST_CAPTURE;
                    end
                end
                ST_ARMED: begin
                    if (qual) begin
                        prev_neg <= sample_neg;
                        if (armed_hit) begin
                            wr_count  <= ONE_LEN;
                            decim_cnt <= decim_l;
                            if (len_l == ONE_LEN) begin
                                state  <= ST_DONE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                state <= ST_CAPTURE;
                            end
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (qual) begin
                        if (decim_cnt == '0) begin
                            wr_count  <= wr_count_inc;
                            decim_cnt <= decim_l;
                            if (wr_count_inc == len_l) begin
                                state  <= ST_DONE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end
                        end else begin
                            decim_cnt <= decim_cnt - DecimWidth'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Read handshake: answer one cycle after RdEn, refusing while capturing
    always_ff @(posedge DAC_clk or posedge rst) begin
        if (rst) begin
            rd_vld_p1  <= 1'b0;
            rd_err_p1  <= 1'b0;
            rd_zero_p1 <= 1'b1;
        end else begin
            rd_vld_p1 <= RdEn;
            if (RdEn) begin
                rd_err_p1  <= capturing;
                rd_zero_p1 <= capturing;
            end
        end
    end

    dds_capture_ram #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) u_ram (
        .clk     (DAC_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (SampleIn),
        .rd_en   (RdEn && !capturing),
        .rd_addr (RdAddress),
        .rd_data (ram_q)
    );

    assign Busy    = busy_r;
    assign Done    = done_r;
    assign WrCount = wr_count;
    assign RdValid = rd_vld_p1;
    assign RdErr   = rd_err_p1;
    // RAM output register is not reset; a zero flag masks it after reset and refused reads
    assign RdData  = rd_zero_p1 ? '0 : ram_q;

endmodule

// File: tb/tb_dds_sample_capture.sv
// Bench for dds_sample_capture: drives capture scenarios, keeps a model of
// what should be in the capture RAM, and scores every read response.
module tb_dds_sample_capture;

    localparam int AW  = 10;
    localparam int DW  = 16;
    localparam int DCW = 8;

    logic          DAC_clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] SampleIn;
    logic          SampleValid;
    logic          Arm;
    logic          Abort;
    logic          TrigMode;
    logic [DCW-1:0] Decim;
    logic [AW:0]   CaptureLen;
    logic          Busy;
    logic          Done;
    logic [AW:0]   WrCount;
    logic          RdEn;
    logic [AW-1:0] RdAddress;
    logic [DW-1:0] RdData;
    logic          RdValid;
    logic          RdErr;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } rd_exp_t;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] mem_model [1<<AW];
    rd_exp_t       rd_q [$];
    logic          rd_issued;

    dds_sample_capture #(
        .AddrWidth  (AW),
        .DataWidth  (DW),
        .DecimWidth (DCW)
    ) dut (
        .DAC_clk     (DAC_clk),
        .rst         (rst),
        .en          (en),
        .SampleIn    (SampleIn),
        .SampleValid (SampleValid),
        .Arm         (Arm),
        .Abort       (Abort),
        .TrigMode    (TrigMode),
        .Decim       (Decim),
        .CaptureLen  (CaptureLen),
        .Busy        (Busy),
        .Done        (Done),
        .WrCount     (WrCount),
        .RdEn        (RdEn),
        .RdAddress   (RdAddress),
        .RdData      (RdData),
        .RdValid     (RdValid),
        .RdErr       (RdErr)
    );

    always #5 DAC_clk = ~DAC_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // remember whether a read was issued at the last edge
    always @(posedge DAC_clk or posedge rst) begin
        if (rst) rd_issued <= 1'b0;
        else     rd_issued <= RdEn;
    end

    // score read responses against the queue of expected answers
    always @(negedge DAC_clk) begin
        rd_exp_t e;
        if (!rst && (rd_issued || RdValid)) begin
            check_eq("rd_valid", {31'b0, RdValid}, {31'b0, rd_issued});
            if (rd_issued && rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check_eq("rd_data", {16'b0, RdData}, {16'b0, e.data});
                check_eq("rd_err", {31'b0, RdErr}, {31'b0, e.err});
            end
        end
    end

    task automatic put(input logic [DW-1:0] d, input logic e, input logic v);
        @(negedge DAC_clk);
        SampleIn    = d;
        en          = e;
        SampleValid = v;
        @(posedge DAC_clk);
        #1;
        SampleValid = 1'b0;
        en          = 1'b0;
    endtask

    task automatic ctl(input logic arm, input logic ab, input logic mode,
                       input logic [DCW-1:0] dec, input logic [AW:0] len);
        @(negedge DAC_clk);
        Arm        = arm;
        Abort      = ab;
        TrigMode   = mode;
        Decim      = dec;
        CaptureLen = len;
        @(posedge DAC_clk);
        #1;
        Arm   = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic err);
        rd_exp_t e;
        @(negedge DAC_clk);
        RdEn      = 1'b1;
        RdAddress = addr;
        e.data    = err ? '0 : mem_model[addr];
        e.err     = err;
        rd_q.push_back(e);
        @(posedge DAC_clk);
        #1;
        RdEn = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic b, input logic d, input int wc);
        check_eq({tag, "_busy"}, {31'b0, Busy}, {31'b0, b});
        check_eq({tag, "_done"}, {31'b0, Done}, {31'b0, d});
        check_eq({tag, "_wrcount"}, {21'b0, WrCount}, wc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] zx [7];
        int n;
        int k;
        logic ev;
        logic [DW-1:0] d;

        rst = 1'b1; en = 1'b0; SampleIn = '0; SampleValid = 1'b0;
        Arm = 1'b0; Abort = 1'b0; TrigMode = 1'b0; Decim = '0;
        CaptureLen = '0; RdEn = 1'b0; RdAddress = '0;

        // reset state
        repeat (3) @(posedge DAC_clk);
        #1;
        chk_status("reset", 1'b0, 1'b0, 0);
        check_eq("reset_rdvalid", {31'b0, RdValid}, 0);
        check_eq("reset_rderr", {31'b0, RdErr}, 0);
        check_eq("reset_rddata", {16'b0, RdData}, 0);
        @(negedge DAC_clk);
        rst = 1'b0;

        // 1: immediate trigger, 8 samples out of 16 offered
        ctl(1'b1, 1'b0, 1'b0, 8'd0, 11'd8);
        chk_status("t1_arm", 1'b1, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            put(DW'(100 + i), 1'b1, 1'b1);
            if (i < 8) mem_model[i] = DW'(100 + i);
            chk_status("t1_run", (i < 7), (i >= 7), (i < 8) ? i + 1 : 8);
        end
        for (int a = 0; a < 8; a++) rd(AW'(a), 1'b0);

        // 2: decimation by 3 with non-qualified cycles mixed in
        ctl(1'b1, 1'b0, 1'b0, 8'd2, 11'd4);
        for (int i = 0; i < 12; i++) begin
            if (i == 4) begin
                put(16'h7777, 1'b0, 1'b1);
                put(16'h5555, 1'b1, 1'b0);
                chk_status("t2_hold", 1'b1, 1'b0, 2);
            end
            put(DW'(i), 1'b1, 1'b1);
            if (i % 3 == 0) mem_model[i / 3] = DW'(i);
        end
        chk_status("t2_end", 1'b0, 1'b1, 4);
        for (int a = 0; a < 4; a++) rd(AW'(a), 1'b0);

        // 3 + 4: rising zero-crossing trigger, reads refused while busy
        zx = '{16'd5, 16'hFFFD, 16'hFFFF, 16'd0, 16'd7, 16'd9, 16'd2};
        ctl(1'b1, 1'b0, 1'b1, 8'd0, 11'd4);
        chk_status("t3_arm", 1'b1, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            put(zx[i], 1'b1, 1'b1);
            if (i >= 3) mem_model[i - 3] = zx[i];
            chk_status("t3_run", (i < 6), (i == 6), (i < 3) ? 0 : i - 2);
            if (i == 1 || i == 4) rd(AW'(0), 1'b1);
        end
        for (int a = 0; a < 4; a++) rd(AW'(a), 1'b0);

        // 5: abort part way, then Arm together with Abort
        ctl(1'b1, 1'b0, 1'b0, 8'd0, 11'd16);
        for (int i = 0; i < 5; i++) begin
            put(DW'(200 + i), 1'b1, 1'b1);
            mem_model[i] = DW'(200 + i);
        end
        ctl(1'b0, 1'b1, 1'b0, 8'd0, 11'd16);
        chk_status("t5_abort", 1'b0, 1'b0, 5);
        for (int a = 0; a < 5; a++) rd(AW'(a), 1'b0);
        ctl(1'b1, 1'b1, 1'b0, 8'd0, 11'd16);
        chk_status("t5_arm_abort", 1'b0, 1'b0, 5);
        put(16'h1234, 1'b1, 1'b1);
        chk_status("t5_idle_sample", 1'b0, 1'b0, 5);

        // 6: full-depth capture with en toggling every 3 cycles
        ctl(1'b1, 1'b0, 1'b0, 8'd0, 11'd0);
        n = 0;
        k = 0;
        while (n < 1028 && k < 5000) begin
            ev = ((k / 3) % 2 == 0);
            d  = DW'(k * 7 + 1);
            put(d, ev, 1'b1);
            if (ev) begin
                if (n < 1024) mem_model[n] = d;
                n++;
                if (n == 1023) chk_status("t6_almost", 1'b1, 1'b0, 1023);
                if (n == 1024) chk_status("t6_full", 1'b0, 1'b1, 1024);
            end
            k++;
        end
        check_eq("t6_qualified", n, 1028);
        chk_status("t6_after", 1'b0, 1'b1, 1024);
        rd(AW'(0), 1'b0);
        rd(AW'(1), 1'b0);
        rd(AW'(511), 1'b0);
        rd(AW'(1023), 1'b0);

        // 6: reset mid-capture, then a normal short capture
        ctl(1'b1, 1'b0, 1'b0, 8'd0, 11'd0);
        for (int i = 0; i < 10; i++) put(DW'(500 + i), 1'b1, 1'b1);
        @(negedge DAC_clk);
        rst = 1'b1;
        #1;
        chk_status("t6_rst", 1'b0, 1'b0, 0);
        check_eq("t6_rst_rdvalid", {31'b0, RdValid}, 0);
        check_eq("t6_rst_rderr", {31'b0, RdErr}, 0);
        check_eq("t6_rst_rddata", {16'b0, RdData}, 0);
        @(negedge DAC_clk);
        rst = 1'b0;
        ctl(1'b1, 1'b0, 1'b0, 8'd0, 11'd2);
        put(16'd300, 1'b1, 1'b1);
        mem_model[0] = 16'd300;
        put(16'd301, 1'b1, 1'b1);
        mem_model[1] = 16'd301;
        chk_status("t6_rearm", 1'b0, 1'b1, 2);
        rd(AW'(0), 1'b0);
        rd(AW'(1), 1'b0);

        repeat (3) @(negedge DAC_clk);
        check_eq("rd_queue_drained", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
